// File: rtl/gpio_mmio_if.sv
// Data-bus port between the core's memory stage and the GPIO peripheral.
// The core drives the address, store strobe and store data. The peripheral
// returns registered read data.
interface gpio_mmio_if;
    logic [31:0] addr;
    logic [2:0]  write_enable;
    logic [31:0] data_in;
    logic [31:0] data_out;

    modport master (
        output addr,
        output write_enable,
        output data_in,
        input  data_out
    );

    modport slave (
        input  addr,
        input  write_enable,
        input  data_in,
        output data_out
    );
endinterface

// File: rtl/gpio_mmio.sv
// Memory-mapped GPIO block with per-pin direction and output registers.
// Pin inputs pass through a two-flop synchroniser. Rising and falling edges
// are latched in sticky write-1-to-clear flags.
// Reads return a registered word, shifted so the addressed byte sits in [7:0].
module gpio_mmio #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_1000,
    parameter int          N_GPIO    = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    gpio_mmio_if.slave        bus,
    inout  wire  [N_GPIO-1:0] gpio
);

    localparam logic [2:0] REG_DIR  = 3'd0;
    localparam logic [2:0] REG_OUT  = 3'd1;
    localparam logic [2:0] REG_IN   = 3'd2;
    localparam logic [2:0] REG_RISE = 3'd3;
    localparam logic [2:0] REG_FALL = 3'd4;
    localparam logic [2:0] REG_SET  = 3'd5;
    localparam logic [2:0] REG_CLR  = 3'd6;

    // Bits at or above N_GPIO are never written.
    localparam logic [31:0] VALID_MASK = (N_GPIO >= 32) ? 32'hFFFF_FFFF
                                                        : ((32'h1 << N_GPIO) - 32'h1);

    // Zero-extend a pin-wide value onto the 32-bit read bus.
    function automatic logic [31:0] widen(input logic [N_GPIO-1:0] v);
        logic [31:0] w;
        w = 32'h0;
        w[N_GPIO-1:0] = v;
        return w;
    endfunction

    logic [N_GPIO-1:0] dir_q, dir_d;
    logic [N_GPIO-1:0] out_q, out_d;
    logic [N_GPIO-1:0] rise_q, rise_d;
    logic [N_GPIO-1:0] fall_q, fall_d;
    logic [N_GPIO-1:0] sync1_q, s2_q, prev_q;
    logic [1:0]        warm_q, warm_d;
    logic [31:0]       data_out_q, data_out_d;

    logic              sel_s;
    logic [2:0]        off_s;
    logic [3:0]        lane_s;
    logic [31:0]       wdata_s;
    logic              strobe_ok_s;
    logic [31:0]       bitmask_s;
    logic              wr_s;
    logic [N_GPIO-1:0] wmask_s;
    logic [N_GPIO-1:0] wbits_s;
    logic [N_GPIO-1:0] rise_clr_s, fall_clr_s;
    logic [N_GPIO-1:0] rise_set_s, fall_set_s;
    logic              armed_s;
    logic [31:0]       rd_word_s;
    logic              unused_s;

    // Unused upper bits of the lane-expanded buses are folded into a sink.
    assign unused_s = ^{bitmask_s, wdata_s};

    // Decode window, register offset and store strobe into a bit mask and replicated data.
    always_comb begin
        sel_s = (bus.addr[31:5] == BASE_ADDR[31:5]);
        off_s = bus.addr[4:2];
        case (bus.write_enable)
            3'b100: begin
                lane_s      = 4'b0001 << bus.addr[1:0];
                wdata_s     = {4{bus.data_in[7:0]}};
                strobe_ok_s = 1'b1;
            end
            3'b010: begin
                // addr[0] is ignored, so a misaligned half lands on its aligned pair.
                lane_s      = bus.addr[1] ? 4'b1100 : 4'b0011;
                wdata_s     = {2{bus.data_in[15:0]}};
                strobe_ok_s = 1'b1;
            end
            3'b001: begin
                lane_s      = 4'b1111;
                wdata_s     = bus.data_in;
                strobe_ok_s = 1'b1;
            end
            default: begin
                lane_s      = 4'b0000;
                wdata_s     = 32'h0;
                strobe_ok_s = 1'b0;
            end
        endcase
        bitmask_s = {{8{lane_s[3]}}, {8{lane_s[2]}}, {8{lane_s[1]}}, {8{lane_s[0]}}} & VALID_MASK;
        wr_s      = sel_s & strobe_ok_s;
        wmask_s   = bitmask_s[N_GPIO-1:0];
        wbits_s   = wdata_s[N_GPIO-1:0] & wmask_s;
    end

    // Next-state for control registers, edge flags and the arming counter.
    always_comb begin
        dir_d      = dir_q;
        out_d      = out_q;
        rise_clr_s = '0;
        fall_clr_s = '0;
        if (wr_s) begin
            case (off_s)
                REG_DIR:  dir_d      = (dir_q & ~wmask_s) | wbits_s;
                REG_OUT:  out_d      = (out_q & ~wmask_s) | wbits_s;
                REG_RISE: rise_clr_s = wbits_s;
                REG_FALL: fall_clr_s = wbits_s;
                REG_SET:  out_d      = out_q | wbits_s;
                REG_CLR:  out_d      = out_q & ~wbits_s;
                default:  dir_d      = dir_q;
            endcase
        end else begin
            dir_d = dir_q;
        end

        // Edge detection waits until the synchroniser and prev hold real pin history.
        armed_s = (warm_q == 2'd3);
        if (armed_s) begin
            rise_set_s = s2_q & ~prev_q;
            fall_set_s = ~s2_q & prev_q;
            warm_d     = warm_q;
        end else begin
            rise_set_s = '0;
            fall_set_s = '0;
            warm_d     = warm_q + 2'd1;
        end

        // A new edge wins over a same-cycle clear of the same bit.
        rise_d = (rise_q & ~rise_clr_s) | rise_set_s;
        fall_d = (fall_q & ~fall_clr_s) | fall_set_s;
    end

    // Read mux: select the register by offset and align the addressed byte to [7:0].
    always_comb begin
        case (off_s)
            REG_DIR:  rd_word_s = widen(dir_q);
            REG_OUT:  rd_word_s = widen(out_q);
            REG_IN:   rd_word_s = widen(s2_q);
            REG_RISE: rd_word_s = widen(rise_q);
            REG_FALL: rd_word_s = widen(fall_q);
            default:  rd_word_s = 32'h0;
        endcase
        if (sel_s) begin
            data_out_d = rd_word_s >> {bus.addr[1:0], 3'b000};
        end else begin
            data_out_d = 32'h0;
        end
    end

    // State registers; reset drops every pin to Hi-Z at once through dir_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dir_q      <= '0;
            out_q      <= '0;
            rise_q     <= '0;
            fall_q     <= '0;
            sync1_q    <= '0;
            s2_q       <= '0;
            prev_q     <= '0;
            warm_q     <= 2'd0;
            data_out_q <= 32'h0;
        end else begin
            dir_q      <= dir_d;
            out_q      <= out_d;
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            sync1_q    <= gpio;
            s2_q       <= sync1_q;
            prev_q     <= s2_q;
            warm_q     <= warm_d;
            data_out_q <= data_out_d;
        end
    end

    assign bus.data_out = data_out_q;

    // Each pin is driven from OUT only while its DIR bit is set.
    for (genvar i = 0; i < N_GPIO; i++) begin : g_pin
        assign gpio[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

endmodule

// File: tb/tb_gpio_mmio.sv
// Randomised scoreboard bench for gpio_mmio. Stimulus updates a behavioural
// register-map model and queues the expected data_out and pin levels. A monitor
// pops and compares at each falling clock edge. Pins have pull-downs, so a
// released pin reads 0.
module tb_gpio_mmio;

    localparam logic [31:0] BASE   = 32'h0000_1000;
    localparam logic [31:0] A_DIR  = BASE + 32'h00;
    localparam logic [31:0] A_OUT  = BASE + 32'h04;
    localparam logic [31:0] A_IN   = BASE + 32'h08;
    localparam logic [31:0] A_RISE = BASE + 32'h0C;
    localparam logic [31:0] A_FALL = BASE + 32'h10;
    localparam logic [31:0] A_SET  = BASE + 32'h14;
    localparam logic [31:0] A_CLR  = BASE + 32'h18;
    localparam logic [2:0]  WB = 3'b100, WH = 3'b010, WW = 3'b001, NO = 3'b000;

    logic       clk;
    logic       rst_n;
    logic [7:0] tb_en;
    logic [7:0] tb_val;
    wire  [7:0] gpio;

    gpio_mmio_if bus ();

    gpio_mmio #(.BASE_ADDR(BASE), .N_GPIO(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .gpio  (gpio)
    );

    for (genvar i = 0; i < 8; i++) begin : g_pad
        assign gpio[i] = tb_en[i] ? tb_val[i] : 1'bz;
        pulldown pd_i (gpio[i]);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [31:0] dout;
        logic [7:0]  pins;
    } exp_t;
    exp_t exp_q[$];
    exp_t mon_e;

    // Reference model state: the register map and the pin values seen at recent edges.
    logic [7:0] m_dir, m_out, m_rise, m_fall;
    logic [7:0] m_hist[3];
    int         m_edges;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic model_reset();
        m_dir = 8'h00; m_out = 8'h00; m_rise = 8'h00; m_fall = 8'h00;
        m_hist[0] = 8'h00; m_hist[1] = 8'h00; m_hist[2] = 8'h00;
        m_edges = 0;
    endtask

    function automatic logic [7:0] resolve(input logic [7:0] dir, input logic [7:0] out,
                                           input logic [7:0] en, input logic [7:0] val);
        return (dir & out) | (~dir & en & val);
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a);
        logic [31:0] r;
        if ((a / 32) != (BASE / 32)) return 32'h0;
        case ((a % 32) / 4)
            32'd0:   r = {24'h0, m_dir};
            32'd1:   r = {24'h0, m_out};
            32'd2:   r = {24'h0, m_hist[1]};
            32'd3:   r = {24'h0, m_rise};
            32'd4:   r = {24'h0, m_fall};
            default: r = 32'h0;
        endcase
        return r >> (8 * (a % 4));
    endfunction

    // One bus cycle: drive at negedge+1, advance the model on the posedge, queue expectations.
    task automatic cycle(input logic [31:0] a, input logic [2:0] we, input logic [31:0] d,
                         input logic [7:0] pen, input logic [7:0] pval);
        logic [31:0] lanes, rep, exp_do;
        logic [7:0]  lanes8, wb8, n_dir, pins_pre, s2, prev, rs, fs;
        logic [31:0] off;
        logic        wr;
        exp_t        e;
        off = (a % 32) / 4;
        wr  = ((a / 32) == (BASE / 32));
        case (we)
            3'b100: begin lanes = 32'h0000_00FF << (8 * (a % 4));         rep = (d & 32'h0000_00FF) * 32'h0101_0101; end
            3'b010: begin lanes = 32'h0000_FFFF << (16 * ((a % 4) / 2));  rep = (d & 32'h0000_FFFF) * 32'h0001_0001; end
            3'b001: begin lanes = 32'hFFFF_FFFF;                          rep = d; end
            default: begin lanes = 32'h0; rep = 32'h0; wr = 1'b0; end
        endcase
        lanes8 = lanes[7:0];
        wb8    = rep[7:0] & lanes8;
        n_dir  = (wr && off == 32'd0) ? ((m_dir & ~lanes8) | wb8) : m_dir;

        @(negedge clk);
        #1;
        bus.addr = a; bus.write_enable = we; bus.data_in = d;
        tb_en  = pen & ~m_dir & ~n_dir;
        tb_val = pval;
        pins_pre = resolve(m_dir, m_out, tb_en, tb_val);
        exp_do   = model_read(a);

        @(posedge clk);
        s2 = m_hist[1]; prev = m_hist[2];
        if (m_edges >= 3) begin rs = s2 & ~prev; fs = ~s2 & prev; end
        else begin rs = 8'h00; fs = 8'h00; end
        if (wr) begin
            case (off)
                32'd0: m_dir  = n_dir;
                32'd1: m_out  = (m_out & ~lanes8) | wb8;
                32'd3: m_rise = m_rise & ~wb8;
                32'd4: m_fall = m_fall & ~wb8;
                32'd5: m_out  = m_out | wb8;
                32'd6: m_out  = m_out & ~wb8;
                default: ;
            endcase
        end
        m_rise = m_rise | rs;
        m_fall = m_fall | fs;
        m_hist[2] = m_hist[1]; m_hist[1] = m_hist[0]; m_hist[0] = pins_pre;
        if (m_edges < 3) m_edges++;
        e.dout = exp_do;
        e.pins = resolve(m_dir, m_out, tb_en, tb_val);
        exp_q.push_back(e);
    endtask

    // Monitor: compare every queued expectation at the falling edge after it was issued.
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("data_out", bus.data_out, mon_e.dout);
            check("gpio", {24'h0, gpio}, {24'h0, mon_e.pins});
        end
    end

    logic [31:0] ra;
    logic [2:0]  rwe;

    initial begin
        rst_n = 1'b0;
        bus.addr = 32'h0; bus.write_enable = 3'b000; bus.data_in = 32'h0;
        tb_en = 8'hFF; tb_val = 8'hFF;
        model_reset();

        // Reset with pins held high, then confirm no RISE after arming.
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset data_out", bus.data_out, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (10) cycle(A_RISE, NO, 32'h0, 8'hFF, 8'hFF);

        // Byte/half/word lane handling.
        cycle(A_DIR, WW, 32'h0000_00F0, 8'h00, 8'h00);
        cycle(A_OUT, WB, 32'h0000_00A5, 8'h00, 8'h00);
        cycle(A_OUT + 32'd1, WB, 32'h0000_005A, 8'h00, 8'h00);
        cycle(A_OUT + 32'd2, WH, 32'h0000_FFFF, 8'h00, 8'h00);
        cycle(A_OUT, NO, 32'h0, 8'h00, 8'h00);

        // SET/CLR aliases.
        cycle(A_OUT, WW, 32'h0000_000F, 8'h00, 8'h00);
        cycle(A_SET, WW, 32'h0000_0030, 8'h00, 8'h00);
        cycle(A_CLR, WW, 32'h0000_0003, 8'h00, 8'h00);
        cycle(A_SET, NO, 32'h0, 8'h00, 8'h00);
        cycle(A_CLR, NO, 32'h0, 8'h00, 8'h00);
        cycle(A_OUT, NO, 32'h0, 8'h00, 8'h00);

        // Edge flags and W1C, including a clear coinciding with a new rise.
        cycle(A_DIR, WW, 32'h0, 8'hFF, 8'h00);
        repeat (4) cycle(A_RISE, NO, 32'h0, 8'hFF, 8'h00);
        cycle(A_RISE, WW, 32'hFF, 8'hFF, 8'h00);
        cycle(A_FALL, WW, 32'hFF, 8'hFF, 8'h00);
        repeat (5) cycle(A_RISE, NO, 32'h0, 8'hFF, 8'h04);
        repeat (4) cycle(A_FALL, NO, 32'h0, 8'hFF, 8'h00);
        cycle(A_RISE, NO, 32'h0, 8'hFF, 8'h04);
        cycle(A_RISE, NO, 32'h0, 8'hFF, 8'h04);
        cycle(A_RISE, WW, 32'h04, 8'hFF, 8'h04);
        cycle(A_RISE, NO, 32'h0, 8'hFF, 8'h04);
        cycle(A_RISE, WW, 32'h04, 8'hFF, 8'h04);
        cycle(A_RISE, NO, 32'h0, 8'hFF, 8'h04);

        // Reads: IN loopback, offset byte read, out-of-window access.
        cycle(A_DIR, WW, 32'hFF, 8'h00, 8'h00);
        cycle(A_OUT, WW, 32'hC3, 8'h00, 8'h00);
        repeat (3) cycle(A_IN, NO, 32'h0, 8'h00, 8'h00);
        cycle(A_OUT + 32'd1, NO, 32'h0, 8'h00, 8'h00);
        cycle(BASE + 32'h24, WW, 32'h0, 8'h00, 8'h00);
        cycle(BASE - 32'h1C, WW, 32'h0, 8'h00, 8'h00);
        cycle(A_OUT, NO, 32'h0, 8'h00, 8'h00);

        // Asynchronous reset between edges with all pins driven high.
        cycle(A_OUT, WW, 32'hFF, 8'h00, 8'h00);
        @(negedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("async reset gpio", {24'h0, gpio}, 32'h0);
        check("async reset data_out", bus.data_out, 32'h0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycle(A_DIR, WW, 32'h0F, 8'h00, 8'h00);
        cycle(A_OUT, WW, 32'h0A, 8'h00, 8'h00);
        cycle(A_OUT, NO, 32'h0, 8'h00, 8'h00);

        // Randomised traffic.
        for (int k = 0; k < 400; k++) begin
            ra = ($urandom_range(0, 9) == 0) ? $urandom : (BASE + $urandom_range(0, 31));
            case ($urandom_range(0, 5))
                0:       rwe = 3'b100;
                1:       rwe = 3'b010;
                2:       rwe = 3'b001;
                3:       rwe = 3'b000;
                4:       rwe = 3'b011;
                default: rwe = 3'b111;
            endcase
            cycle(ra, rwe, $urandom, 8'($urandom), 8'($urandom));
        end

        @(negedge clk); #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
